axi_gpio_bank: RTL and testbench

Parametrised AXI4-Lite slave exposing NUM_REGS external registers over flattened buses. It is the generalised successor of the fixed five-register axi_gpio, with the same per-register we/valid side interface. It adds:
- configurable width and depth;
- byte-strobe merging;
- independent AW/W acceptance;
- SLVERR for out-of-range addresses;
- a read timeout when an external register never asserts valid.

---
 rtl/axi_gpio_bank.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_axi_gpio_bank.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_gpio_bank.sv
// AXI4-Lite slave fronting NUM_REGS external registers through per-register
// write-enable / valid side buses, with byte-strobe merging and a read timeout.
module axi_gpio_bank #(
    parameter int NUM_REGS     = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 6,
    parameter int READ_TIMEOUT = 16
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] slv_reg_out,
    output logic [NUM_REGS-1:0]            slv_reg_we_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] slv_reg_in,
    input  logic [NUM_REGS-1:0]            slv_reg_valid
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int CNT_W    = $clog2(READ_TIMEOUT + 1);
    localparam int BUS_W    = NUM_REGS * DATA_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_STROBE = 2'd1, W_RESP = 2'd2} wstate_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rstate_e;

    function automatic logic [DATA_WIDTH-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int b = 0; b < STRB_W; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] slice_of(input logic [BUS_W-1:0] bus,
                                                       input logic [IDX_W-1:0] idx);
        logic [DATA_WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            s = (IDX_W'(i) == idx) ? bus[i*DATA_WIDTH +: DATA_WIDTH] : s;
        end
        return s;
    endfunction

    function automatic logic bit_of(input logic [NUM_REGS-1:0] vec, input logic [IDX_W-1:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            b = (IDX_W'(i) == idx) ? vec[i] : b;
        end
        return b;
    endfunction

    function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
        return (32'(idx) < 32'(NUM_REGS));
    endfunction

    wstate_e                 wstate_q, wstate_d;
    logic                    aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]        awidx_q, awidx_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d, wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [BUS_W-1:0]        reg_out_q, reg_out_d;
    logic [NUM_REGS-1:0]     reg_we_q, reg_we_d;

    rstate_e                 rstate_q, rstate_d;
    logic [IDX_W-1:0]        aridx_q, aridx_d;
    logic [CNT_W-1:0]        rcnt_q, rcnt_d;
    logic                    arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                    aw_fire_s, w_fire_s, ar_fire_s;
    logic [DATA_WIDTH-1:0]   wr_mask_s, wr_cur_s, wr_merged_s;
    logic                    addr_lsb_unused_s;

    assign aw_fire_s   = S_AXI_AWVALID & awready_q;
    assign w_fire_s    = S_AXI_WVALID & wready_q;
    assign ar_fire_s   = S_AXI_ARVALID & arready_q;
    assign wr_mask_s   = strb_mask(wstrb_q);
    assign wr_cur_s    = slice_of(slv_reg_in, awidx_q);
    assign wr_merged_s = (wr_cur_s & ~wr_mask_s) | (wdata_q & wr_mask_s);
    // Sub-word address bits carry no register selection.
    assign addr_lsb_unused_s = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    // Write channel next-state: independent AW/W capture, strobe merge, response hold
    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg_out_d = reg_out_q;
        reg_we_d  = '0;
        case (wstate_q)
            W_IDLE: begin
                if (aw_fire_s) begin
                    aw_held_d = 1'b1;
                    awidx_d   = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
                end else begin
                    aw_held_d = aw_held_q;
                end
                if (w_fire_s) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                end else begin
                    w_held_d = w_held_q;
                end
                if (aw_held_d && w_held_d) begin
                    wstate_d  = W_STROBE;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    awready_d = ~aw_held_d;
                    wready_d  = ~w_held_d;
                end
            end
            W_STROBE: begin
                wstate_d  = W_RESP;
                bvalid_d  = 1'b1;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                if (!idx_in_range(awidx_q)) begin
                    bresp_d = RESP_SLVERR;
                end else if (wstrb_q != '0) begin
                    bresp_d = RESP_OKAY;
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (IDX_W'(i) == awidx_q) begin
                            reg_we_d[i] = 1'b1;
                            reg_out_d[i*DATA_WIDTH +: DATA_WIDTH] = wr_merged_s;
                        end else begin
                            reg_we_d[i] = 1'b0;
                        end
                    end
                end else begin
                    bresp_d = RESP_OKAY;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                wstate_d  = W_IDLE;
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
            end
        endcase
    end

    // Write channel state, response and register-bank outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wstate_q  <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            reg_out_q <= '0;
            reg_we_q  <= '0;
        end else begin
            wstate_q  <= wstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            reg_out_q <= reg_out_d;
            reg_we_q  <= reg_we_d;
        end
    end

    // Read channel next-state: wait for the register's valid, or give up after READ_TIMEOUT
    always_comb begin
        rstate_d  = rstate_q;
        aridx_d   = aridx_q;
        rcnt_d    = rcnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_fire_s) begin
                    aridx_d   = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
                    rcnt_d    = '0;
                    arready_d = 1'b0;
                    rstate_d  = R_WAIT;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_WAIT: begin
                if (!idx_in_range(aridx_q)) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                end else if (bit_of(slv_reg_valid, aridx_q)) begin
                    rdata_d  = slice_of(slv_reg_in, aridx_q);
                    rresp_d  = RESP_OKAY;
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                end else if (rcnt_q == CNT_W'(READ_TIMEOUT - 1)) begin
                    rdata_d  = '0;
                    rresp_d  = RESP_SLVERR;
                    rvalid_d = 1'b1;
                    rstate_d = R_DATA;
                end else begin
                    rcnt_d = rcnt_q + CNT_W'(1);
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                rstate_d  = R_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // Read channel state and response registers
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rstate_q  <= R_IDLE;
            aridx_q   <= '0;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            aridx_q   <= aridx_d;
            rcnt_q    <= rcnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign S_AXI_AWREADY  = awready_q;
    assign S_AXI_WREADY   = wready_q;
    assign S_AXI_BVALID   = bvalid_q;
    assign S_AXI_BRESP    = bresp_q;
    assign S_AXI_ARREADY  = arready_q;
    assign S_AXI_RVALID   = rvalid_q;
    assign S_AXI_RRESP    = rresp_q;
    assign S_AXI_RDATA    = rdata_q;
    assign slv_reg_out    = reg_out_q;
    assign slv_reg_we_out = reg_we_q;

endmodule

// File: tb/tb_axi_gpio_bank.sv
// Scoreboard bench for axi_gpio_bank: stimulus pushes expected B/R/we events,
// independent monitors pop and compare whenever the DUT presents them.
module tb_axi_gpio_bank;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam int AW = 6;
    localparam int RT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [AW-1:0]     AWADDR, ARADDR;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0]     WDATA, RDATA;
    logic [DW/8-1:0]   WSTRB;
    logic [1:0]        BRESP, RRESP;
    logic [NR*DW-1:0]  slv_reg_out, slv_reg_in;
    logic [NR-1:0]     slv_we, slv_valid;

    axi_gpio_bank #(.NUM_REGS(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_TIMEOUT(RT)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .slv_reg_out(slv_reg_out), .slv_reg_we_out(slv_we),
        .slv_reg_in(slv_reg_in), .slv_reg_valid(slv_valid)
    );

    typedef struct { int idx; logic [DW-1:0] data; } we_t;
    typedef struct { logic [DW-1:0] data; logic [1:0] resp; } rd_t;
    we_t        weq[$];
    rd_t        rq[$];
    logic [1:0] bq[$];

    int tests = 0;
    int fails = 0;

    // External registers: load on write-enable, preset from ext_init
    logic [DW-1:0] ext_reg [NR];
    logic [DW-1:0] ext_init [NR];
    logic          load_ext;
    // Reference model: mdl_in = what slv_reg_in should show, mdl_out = slv_reg_out
    logic [DW-1:0] mdl_in [NR];
    logic [DW-1:0] mdl_out [NR];

    always_comb begin
        slv_reg_in = '0;
        for (int i = 0; i < NR; i++) slv_reg_in[i*DW +: DW] = ext_reg[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (load_ext) ext_reg[i] <= ext_init[i];
            else if (slv_we[i]) ext_reg[i] <= slv_reg_out[i*DW +: DW];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        if (idx >= NR) begin
            bq.push_back(2'b10);
        end else begin
            bq.push_back(2'b00);
            if (strb != 4'd0) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mdl_in[idx][b*8 +: 8] = data[b*8 +: 8];
                mdl_out[idx] = mdl_in[idx];
                weq.push_back('{idx, mdl_in[idx]});
            end
        end
    endtask

    task automatic model_read(input logic [AW-1:0] addr, output logic [DW-1:0] d, output logic [1:0] r);
        int idx;
        idx = int'(addr) / 4;
        if (idx >= NR) begin d = '0; r = 2'b10; end
        else begin d = mdl_in[idx]; r = 2'b00; end
    endtask

    // Waits until the selected READY is seen with VALID up; returns #1 after the handshake edge
    task automatic wait_ready(input int ch);
        int n;
        n = 0;
        @(negedge clk);
        while (!((ch == 0) ? AWREADY : (ch == 1) ? WREADY : ARREADY) && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (n >= 64) begin
            tests++; fails++;
            $display("FAIL ready_timeout: channel %0d never ready", ch);
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        model_write(addr, data, strb);
        @(posedge clk); #1;
        fork
            begin
                repeat (aw_dly) begin @(posedge clk); #1; end
                AWADDR = addr; AWVALID = 1'b1;
                wait_ready(0);
                AWVALID = 1'b0;
                check("awready_drop", AWREADY, 0);
            end
            begin
                repeat (w_dly) begin @(posedge clk); #1; end
                WDATA = data; WSTRB = strb; WVALID = 1'b1;
                wait_ready(1);
                WVALID = 1'b0;
                check("wready_drop", WREADY, 0);
            end
        join
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                            input logic [1:0] exp_resp, input int exp_lat, input int valid_dly);
        int n;
        int idx;
        rq.push_back('{exp_data, exp_resp});
        idx = int'(addr) / 4;
        @(posedge clk); #1;
        ARADDR = addr; ARVALID = 1'b1;
        wait_ready(2);
        ARVALID = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (!RVALID && n == valid_dly && idx < NR) slv_valid[idx] = 1'b1;
        end while (!RVALID && n < 200);
        check("rd_latency", 64'(n + 1), 64'(exp_lat));
    endtask

    // Monitors: B, R and write-enable events popped from the scoreboard queues
    we_t        we_e;
    rd_t        rd_e;
    logic [1:0] b_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected: BRESP %b with nothing expected", BRESP);
                end else begin
                    b_e = bq.pop_front();
                    check("bresp", BRESP, b_e);
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL r_unexpected: RDATA %h with nothing expected", RDATA);
                end else begin
                    rd_e = rq.pop_front();
                    check("rdata", RDATA, rd_e.data);
                    check("rresp", RRESP, rd_e.resp);
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (slv_we[i]) begin
                    if (weq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL we_unexpected: pulse on bit %0d", i);
                    end else begin
                        we_e = weq.pop_front();
                        check("we_idx", 64'(i), 64'(we_e.idx));
                        check("we_data", slv_reg_out[i*DW +: DW], we_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] d;
    logic [1:0]    r;
    int            n;

    initial begin
        rst_n = 1'b0; load_ext = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1; slv_valid = '1;
        for (int i = 0; i < NR; i++) begin
            ext_init[i] = $urandom;
            mdl_in[i]   = ext_init[i];
            mdl_out[i]  = '0;
        end
        #1;
        check("reset_ctrl", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP}, 0);
        check("reset_rdata", RDATA, 0);
        check("reset_regout", {63'd0, |slv_reg_out}, 0);
        check("reset_we", slv_we, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; load_ext = 1'b0;

        // Alternating patterns across every register, then read all back
        for (int i = 0; i < NR; i++)
            axi_write(6'(i * 4), (i % 2 == 1) ? 32'hCAFE1234 : 32'hFACEB00C, 4'hF, 0, 0);
        for (int i = 0; i < NR; i++)
            axi_read(6'(i * 4), (i % 2 == 1) ? 32'hCAFE1234 : 32'hFACEB00C, 2'b00, 2, -1);

        // Byte-strobe merge
        axi_write(6'h08, 32'h11223344, 4'hF, 0, 0);
        axi_write(6'h08, 32'hAABBCCDD, 4'b0101, 0, 0);
        axi_read(6'h08, 32'h11BB33DD, 2'b00, 2, -1);

        // Out-of-range write and read
        axi_write(6'h20, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read(6'h3C, 32'h0, 2'b10, 2, -1);

        // AW before W, then W before AW
        axi_write(6'h0C, 32'h01020304, 4'hF, 0, 3);
        axi_write(6'h10, 32'hA5A5F00F, 4'hF, 3, 0);

        // Read timeout, then valid rising four cycles after acceptance
        slv_valid[5] = 1'b0;
        axi_read(6'h14, 32'h0, 2'b10, RT + 1, -1);
        slv_valid[5] = 1'b0;
        axi_read(6'h14, mdl_in[5], 2'b00, 6, 4);

        // Randomised mix, including out-of-range addresses and unaligned low bits
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 9) < 8) a = 6'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
            else a = 6'($urandom_range(32, 63));
            if ($urandom_range(0, 1) == 0) begin
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                model_read(a, d, r);
                axi_read(a, d, r, 2, -1);
            end
        end

        // Back-pressure on B: response must hold
        @(posedge clk); #1 BREADY = 1'b0;
        axi_write(6'h30, 32'h12345678, 4'hF, 0, 0);
        n = 0;
        while (!BVALID && n < 20) begin @(negedge clk); n++; end
        repeat (4) begin
            @(negedge clk);
            check("b_stall", {BVALID, BRESP}, {1'b1, 2'b10});
        end
        @(posedge clk); #1 BREADY = 1'b1;

        // Back-pressure on R: data and response must hold
        RREADY = 1'b0;
        axi_read(6'h08, mdl_in[2], 2'b00, 2, -1);
        repeat (4) begin
            @(negedge clk);
            check("r_stall", {RVALID, RRESP, RDATA}, {1'b1, 2'b00, mdl_in[2]});
        end
        @(posedge clk); #1 RREADY = 1'b1;
        repeat (2) @(posedge clk);

        // Reset with an address captured but no data: aborts without a we pulse
        #1 AWADDR = 6'h08; AWVALID = 1'b1;
        wait_ready(0);
        AWVALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RRESP}, 0);
        check("midrst_rdata", RDATA, 0);
        check("midrst_regout", {63'd0, |slv_reg_out}, 0);
        check("midrst_we", slv_we, 0);
        for (int i = 0; i < NR; i++) mdl_out[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        axi_write(6'h1C, 32'h0BADF00D, 4'hF, 1, 0);
        axi_read(6'h1C, 32'h0BADF00D, 2'b00, 2, -1);
        repeat (5) @(posedge clk);

        #1;
        check("bq_drained", 64'(bq.size()), 0);
        check("rq_drained", 64'(rq.size()), 0);
        check("weq_drained", 64'(weq.size()), 0);
        for (int i = 0; i < NR; i++)
            check("final_regout", slv_reg_out[i*DW +: DW], mdl_out[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
